keypad_scan_queue: RTL and testbench
====================================

# keypad_scan_queue

Parametrised keypad scanner with debounce on press and release, and a ready/valid key FIFO. It drives active-low columns and reads synchronised active-low rows. Each debounced press becomes a linear key index, which is buffered for a consumer such as a display or sequencer. It is the successor to the single-key 4x4 scanner: it adds matrix size, scan rate, queue depth, release debounce, row priority and optional auto-repeat.

## Interface
- NROWS, 4: row count, ≥2
- NCOLS, 4: column count, ≥2
- SCAN_DIV, 4: clocks each column is driven during scanning, ≥1
- DEBOUNCE, 50000: press and release debounce length in clocks, ≥1
- FIFO_DEPTH, 4: key queue entries, power of 2, ≥2
- REPEAT_DELAY, 500000: clocks held before the first repeat (used only with TYPEMATIC_EN)
- REPEAT_PERIOD, 100000: clocks between repeats (used only with TYPEMATIC_EN)
- int_osc  in  1  sole clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- sync  in  NROWS  row inputs, active-low, already synchronised to int_osc
- cols  out  NCOLS  column drive, active-low, one-cold
- key_valid  out  1  queue not empty
- key_idx  out  KW = $clog2(NROWS*NCOLS)  head entry, row*NCOLS+col
- key_ready  in  1  consumer accepts head when key_valid is high
- fifo_full  out  1  queue holds FIFO_DEPTH entries
- overflow  out  1  one-cycle pulse when a key is dropped

## Operation
- States: SCAN, PDB (press debounce), CONFIRM, HELD, RDB (release debounce).
- Reset values:
  - state SCAN, column index 0, so cols = ~(1<<0).
  - All counters 0.
  - Queue empty: key_valid=0, key_idx=0, fifo_full=0, overflow=0.
- SCAN:
  - Drive column c low. Advance c after SCAN_DIV clocks, wrapping NCOLS-1→0.
  - If any sync bit is low, latch c and the lowest-index low row r, then go to PDB.
  - The column index stops advancing.
- PDB:
  - Keep driving c.
  - After exactly DEBOUNCE clocks, go to CONFIRM.
  - Row activity during PDB is ignored.
- CONFIRM (one clock):
  - If sync[r]==0, push r*NCOLS+c and go to HELD.
  - Otherwise go to SCAN and resume scanning at c.
- HELD:
  - Keep driving c.
  - sync[r]==1 → RDB.
  - Other rows going low are ignored. There is no second key and no rollover.
- RDB:
  - Keep driving c and count.
  - If sync[r] returns to 0 before DEBOUNCE clocks, go back to HELD with no new push.
  - After DEBOUNCE consecutive high clocks, go to SCAN and advance to c+1 (mod NCOLS).
- Queue:
  - Circular buffer with a count register.
  - Pop when key_valid && key_ready.
  - A push while full without a pop drops the new key and pulses overflow for one clock. Queue contents are unchanged.
  - A push and pop in the same clock while full are both accepted and the count is unchanged.
  - A push and pop in the same clock while empty: the push is stored and the pop is impossible, since key_valid=0.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- Reset asserted in any state returns every register to its reset value asynchronously. Queued keys are lost.

## Timing
- cols and key_idx are combinational from registers. key_valid and fifo_full come from the count register.
- Press latency: the edge that samples the low row is edge 0. PDB occupies the following DEBOUNCE clocks, then CONFIRM follows. key_valid rises after edge DEBOUNCE+2.
- Column dwell during scanning is exactly SCAN_DIV clocks.
- Full scan period: NCOLS*SCAN_DIV clocks.
- A pop takes effect on the accepting edge. The next entry appears on key_idx in the following cycle.

## Configuration
- TYPEMATIC_EN defined:
  - In HELD, a repeat counter clears on entry. The same key is pushed after REPEAT_DELAY clocks, then every REPEAT_PERIOD clocks while still in HELD.
  - The counter clears on any exit from HELD, including the RDB→HELD bounce.
  - Repeats obey the overflow rules.
- TYPEMATIC_EN undefined: exactly one push per confirmed press. REPEAT_* are unused and no repeat logic is synthesised.

## Test plan
- Single press: NROWS=NCOLS=4, DEBOUNCE=8, SCAN_DIV=4. Hold row 2 low while col 1 is driven → key_valid rises after edge 10 with key_idx=9. Pop → key_valid=0. Release → no further push.
- Glitch reject: row low for 3 clocks, then high before CONFIRM → no push; scanning resumes at the same column.
- Release bounce: in HELD, toggle sync[r] high for 5 clocks then low (DEBOUNCE=8) → state returns to HELD, no second push. Holding it high for 8 clocks → SCAN at c+1.
- Overflow: FIFO_DEPTH=4, key_ready=0, five distinct presses → fifo_full=1 after the 4th, one overflow pulse on the 5th, and the head still equals the first key.
- Simultaneous push/pop while full (key_ready=1 on the push clock) → no overflow, count stays 4, order preserved.
- TYPEMATIC_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10: hold a key 45 clocks past CONFIRM → 1 initial push plus 3 repeats, all with the same key_idx. Mid-hold reset → all outputs at reset values.

Source files
------------

// File: rtl/keypad_scan_queue_if.sv
// Keypad scanner bus: matrix drive/sense plus the ready/valid key queue head.
interface keypad_scan_queue_if #(
  parameter int NROWS = 4,
  parameter int NCOLS = 4,
  parameter int KW    = $clog2(NROWS*NCOLS)
);
  logic [NROWS-1:0] sync;
  logic [NCOLS-1:0] cols;
  logic             key_valid;
  logic [KW-1:0]    key_idx;
  logic             key_ready;
  logic             fifo_full;
  logic             overflow;

  modport master (
    input  sync, key_ready,
    output cols, key_valid, key_idx, fifo_full, overflow
  );

  modport slave (
    output sync, key_ready,
    input  cols, key_valid, key_idx, fifo_full, overflow
  );
endinterface

// File: rtl/keypad_scan_queue.sv
// Keypad matrix scanner with press/release debounce and a key FIFO.
// Optional auto-repeat while a key is held: define TYPEMATIC_EN.
module keypad_scan_queue #(
  parameter int NROWS         = 4,
  parameter int NCOLS         = 4,
  parameter int SCAN_DIV      = 4,
  parameter int DEBOUNCE      = 50000,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic               int_osc,
  input  logic               reset,
  keypad_scan_queue_if.master bus
);
  localparam int KW  = $clog2(NROWS*NCOLS);
  localparam int RW  = $clog2(NROWS);
  localparam int CW  = $clog2(NCOLS);
  localparam int DVW = $clog2(SCAN_DIV+1);
  localparam int DBW = $clog2(DEBOUNCE+1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {SCAN, PDB, CONFIRM, HELD, RDB} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0]  r_col,   w_col_n;
  logic [DVW-1:0] r_div,   w_div_n;
  logic [DBW-1:0] r_dcnt,  w_dcnt_n;
  logic [RW-1:0]  r_row,   w_row_n;
  logic           r_push,  w_push_n;

  logic           w_any_low;
  logic [RW-1:0]  w_low_row;
  logic           w_row_up;
  logic [CW-1:0]  w_col_inc;
  logic [KW-1:0]  w_key;

`ifdef TYPEMATIC_EN
  localparam int RPMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW   = $clog2(RPMAX+1);
  logic [RPW-1:0] r_rep, w_rep_n;
  logic           r_first, w_first_n;
  logic [RPW-1:0] w_rep_lim;
  assign w_rep_lim = r_first ? RPW'(REPEAT_DELAY-1) : RPW'(REPEAT_PERIOD-1);
`else
  // Repeat timing only matters when auto-repeat is built in.
  logic w_unused_rep_cfg;
  assign w_unused_rep_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

  // Lowest-index active row wins when several rows are low.
  always_comb begin
    w_any_low = 1'b0;
    w_low_row = '0;
    for (int i = NROWS-1; i >= 0; i--) begin
      if (!bus.sync[i]) begin
        w_any_low = 1'b1;
        w_low_row = RW'(i);
      end
    end
  end

  assign w_row_up  = bus.sync[r_row];
  assign w_col_inc = (r_col == CW'(NCOLS-1)) ? '0 : r_col + 1'b1;
  assign w_key     = KW'(KW'(r_row) * KW'(NCOLS) + KW'(r_col));

  // Next-state and scan/debounce counter logic.
  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_div_n   = r_div;
    w_dcnt_n  = r_dcnt;
    w_row_n   = r_row;
    w_push_n  = 1'b0;
`ifdef TYPEMATIC_EN
    w_rep_n   = '0;
    w_first_n = 1'b1;
`endif
    case (r_state)
      SCAN: begin
        if (w_any_low) begin
          w_state_n = PDB;
          w_row_n   = w_low_row;
          w_div_n   = '0;
          w_dcnt_n  = '0;
        end else if (r_div == DVW'(SCAN_DIV-1)) begin
          w_div_n = '0;
          w_col_n = w_col_inc;
        end else begin
          w_div_n = r_div + 1'b1;
        end
      end
      PDB: begin
        if (r_dcnt == DBW'(DEBOUNCE-1)) begin
          w_state_n = CONFIRM;
          w_dcnt_n  = '0;
        end else begin
          w_dcnt_n = r_dcnt + 1'b1;
        end
      end
      CONFIRM: begin
        if (!w_row_up) begin
          w_state_n = HELD;
          w_push_n  = 1'b1;
        end else begin
          w_state_n = SCAN;
          w_div_n   = '0;
        end
      end
      HELD: begin
        if (w_row_up) begin
          w_state_n = RDB;
          w_dcnt_n  = '0;
        end
`ifdef TYPEMATIC_EN
        else if (r_rep == w_rep_lim) begin
          w_push_n  = 1'b1;
          w_rep_n   = '0;
          w_first_n = 1'b0;
        end else begin
          w_rep_n   = r_rep + 1'b1;
          w_first_n = r_first;
        end
`endif
      end
      RDB: begin
        if (!w_row_up) begin
          w_state_n = HELD;
          w_dcnt_n  = '0;
        end else if (r_dcnt == DBW'(DEBOUNCE-1)) begin
          w_state_n = SCAN;
          w_col_n   = w_col_inc;
          w_div_n   = '0;
          w_dcnt_n  = '0;
        end else begin
          w_dcnt_n = r_dcnt + 1'b1;
        end
      end
      default: w_state_n = SCAN;
    endcase
  end

  // Scanner state registers; the push request is staged one clock before the queue.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      r_state <= SCAN;
      r_col   <= '0;
      r_div   <= '0;
      r_dcnt  <= '0;
      r_row   <= '0;
      r_push  <= 1'b0;
`ifdef TYPEMATIC_EN
      r_rep   <= '0;
      r_first <= 1'b1;
`endif
    end else begin
      r_state <= w_state_n;
      r_col   <= w_col_n;
      r_div   <= w_div_n;
      r_dcnt  <= w_dcnt_n;
      r_row   <= w_row_n;
      r_push  <= w_push_n;
`ifdef TYPEMATIC_EN
      r_rep   <= w_rep_n;
      r_first <= w_first_n;
`endif
    end
  end

  // Key queue: circular buffer plus occupancy count.
  logic [FIFO_DEPTH-1:0][KW-1:0] r_mem;
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_cnt;
  logic          r_ovf;
  logic          w_full, w_valid, w_pop, w_wr;

  assign w_full  = (r_cnt == (PW+1)'(FIFO_DEPTH));
  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid && bus.key_ready;
  assign w_wr    = r_push && (!w_full || w_pop);

  // Queue storage, pointers, count and drop pulse.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= w_key;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_ovf <= r_push && w_full && !w_pop;
    end
  end

  assign bus.cols      = ~(NCOLS'(1) << r_col);
  assign bus.key_valid = w_valid;
  assign bus.key_idx   = r_mem[r_rd];
  assign bus.fifo_full = w_full;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_keypad_scan_queue.sv
// Directed bench for keypad_scan_queue with a single-key matrix model.
module tb_keypad_scan_queue;
  logic int_osc = 1'b0;
  logic reset;
  logic press;
  int   prow, pcol;
  int   checks = 0;
  int   errors = 0;
  int   ovf_cnt = 0;

  keypad_scan_queue_if #(.NROWS(4), .NCOLS(4)) bus ();

  keypad_scan_queue #(
    .NROWS(4), .NCOLS(4), .SCAN_DIV(4), .DEBOUNCE(8), .FIFO_DEPTH(4),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
  ) dut (
    .int_osc(int_osc),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 int_osc = ~int_osc;

  // One key at (prow,pcol): its row reads low only while its column is driven.
  always_comb begin
    bus.sync = '1;
    if (press && !bus.cols[pcol]) bus.sync[prow] = 1'b0;
  end

  always @(negedge int_osc) if (bus.overflow) ovf_cnt <= ovf_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge int_osc);
  endtask

  // Wait (bounded) for column c to be driven, then press; the next rising edge is edge 0.
  task automatic press_at(input int r, input int c);
    logic [3:0] want;
    want = ~(4'b0001 << c);
    prow = r;
    pcol = c;
    for (int i = 0; i < 64 && bus.cols !== want; i++) @(negedge int_osc);
    chk("col_reach", {28'd0, bus.cols}, {28'd0, want});
    press = 1'b1;
  endtask

  task automatic do_press(input int r, input int c);
    press_at(r, c);
    clk_n(12);
    press = 1'b0;
    clk_n(12);
  endtask

  task automatic pop_chk(input string tag, input int exp);
    chk({tag, "_valid"}, {31'd0, bus.key_valid}, 32'd1);
    chk({tag, "_idx"}, {28'd0, bus.key_idx}, exp);
    bus.key_ready = 1'b1;
    clk_n(1);
    bus.key_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    press = 1'b0;
    prow = 0;
    pcol = 0;
    bus.key_ready = 1'b0;
    clk_n(1);
    chk("rst_cols",  {28'd0, bus.cols}, 32'hE);
    chk("rst_valid", {31'd0, bus.key_valid}, 32'd0);
    chk("rst_idx",   {28'd0, bus.key_idx}, 32'd0);
    chk("rst_full",  {31'd0, bus.fifo_full}, 32'd0);
    chk("rst_ovf",   {31'd0, bus.overflow}, 32'd0);
    reset = 1'b1;
    clk_n(2);

    // Single press row 2, col 1: valid appears after edge 10, index 9.
    press_at(2, 1);
    clk_n(10);
    chk("lat_pre", {31'd0, bus.key_valid}, 32'd0);
    clk_n(1);
    chk("lat_post", {31'd0, bus.key_valid}, 32'd1);
    chk("lat_idx", {28'd0, bus.key_idx}, 32'd9);
    bus.key_ready = 1'b1;
    clk_n(1);
    bus.key_ready = 1'b0;
    chk("pop_empty", {31'd0, bus.key_valid}, 32'd0);
`ifndef TYPEMATIC_EN
    clk_n(30);
    chk("no_repeat", {31'd0, bus.key_valid}, 32'd0);
`endif
    // Release bounce of 5 clocks returns to HELD without a new key.
    press = 1'b0;
    clk_n(5);
    press = 1'b1;
    clk_n(6);
    chk("bounce_col", {28'd0, bus.cols}, 32'hD);
    chk("bounce_nopush", {31'd0, bus.key_valid}, 32'd0);
    // Real release: scanning moves on to column 2.
    press = 1'b0;
    clk_n(11);
    chk("release_adv", {28'd0, bus.cols}, 32'hB);
    chk("release_nopush", {31'd0, bus.key_valid}, 32'd0);

    // Glitch on row 1, col 3: no key, scan resumes on col 3 then wraps.
    press_at(1, 3);
    clk_n(3);
    press = 1'b0;
    clk_n(9);
    chk("glitch_nopush", {31'd0, bus.key_valid}, 32'd0);
    chk("glitch_col", {28'd0, bus.cols}, 32'h7);
    clk_n(2);
    chk("glitch_adv", {28'd0, bus.cols}, 32'hE);

    // Overflow: four keys fill the queue, the fifth is dropped.
    do_press(0, 0);
    do_press(1, 2);
    do_press(3, 3);
    do_press(2, 0);
    chk("fill_full", {31'd0, bus.fifo_full}, 32'd1);
    chk("fill_noovf", ovf_cnt, 32'd0);
    do_press(0, 3);
    chk("ovf_pulse", ovf_cnt, 32'd1);
    chk("ovf_full", {31'd0, bus.fifo_full}, 32'd1);
    chk("ovf_head", {28'd0, bus.key_idx}, 32'd0);
    pop_chk("ovf_d0", 0);
    pop_chk("ovf_d1", 6);
    pop_chk("ovf_d2", 15);
    pop_chk("ovf_d3", 8);
    chk("ovf_drained", {31'd0, bus.key_valid}, 32'd0);

    // Push and pop on the same edge while full.
    do_press(3, 0);
    do_press(0, 1);
    do_press(2, 2);
    do_press(1, 1);
    chk("sim_prefull", {31'd0, bus.fifo_full}, 32'd1);
    press_at(3, 2);
    clk_n(10);
    bus.key_ready = 1'b1;
    clk_n(1);
    bus.key_ready = 1'b0;
    chk("sim_full", {31'd0, bus.fifo_full}, 32'd1);
    chk("sim_noovf", ovf_cnt, 32'd1);
    chk("sim_head", {28'd0, bus.key_idx}, 32'd1);
    press = 1'b0;
    clk_n(12);
    pop_chk("sim_d0", 1);
    pop_chk("sim_d1", 10);
    pop_chk("sim_d2", 5);
    pop_chk("sim_d3", 14);
    chk("sim_drained", {31'd0, bus.key_valid}, 32'd0);

`ifdef TYPEMATIC_EN
    // Held ~45 clocks past CONFIRM: initial key plus three repeats.
    press_at(1, 2);
    clk_n(54);
    press = 1'b0;
    clk_n(12);
    chk("rep_full", {31'd0, bus.fifo_full}, 32'd1);
    chk("rep_noovf", ovf_cnt, 32'd1);
    pop_chk("rep_d0", 6);
    pop_chk("rep_d1", 6);
    pop_chk("rep_d2", 6);
    pop_chk("rep_d3", 6);
    chk("rep_drained", {31'd0, bus.key_valid}, 32'd0);
`endif

    // Reset while a key is held and queued.
    press_at(0, 2);
    clk_n(14);
    chk("pre_rst_valid", {31'd0, bus.key_valid}, 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_cols",  {28'd0, bus.cols}, 32'hE);
    chk("mid_rst_valid", {31'd0, bus.key_valid}, 32'd0);
    chk("mid_rst_idx",   {28'd0, bus.key_idx}, 32'd0);
    chk("mid_rst_full",  {31'd0, bus.fifo_full}, 32'd0);
    chk("mid_rst_ovf",   {31'd0, bus.overflow}, 32'd0);
    press = 1'b0;
    clk_n(1);
    reset = 1'b1;
    clk_n(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
